// File: rtl/fp_pkg.sv
// fp_pkg: shared widths and FSM encoding for the sequential single-precision adder.
package fp_pkg;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int EXP_MAX = 255;
    localparam int SUM_W   = MAN_W + 2;
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
endpackage

// File: rtl/fp_align_shift.sv
// fp_align_shift: one-cycle right barrel shift of a 24-bit mantissa; shifts of 24 or more yield zero.
module fp_align_shift
    import fp_pkg::*;
(
    input  logic [MAN_W:0]   mant,
    input  logic [EXP_W-1:0] amt,
    output logic [MAN_W:0]   shifted
);
    assign shifted = (amt > EXP_W'(MAN_W)) ? '0 : mant >> amt;
endmodule

// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle IEEE-754 single adder (truncating, no denormals, no NaN/Inf handling).
// NORM shifts left one bit per cycle, so latency grows with cancellation depth.
module fp_add_seq
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf
);
    state_t             state;
    logic [31:0]        op_a, op_b;
    logic [EXP_W-1:0]   ea, eb, big_e, small_e, exp_r;
    logic [MAN_W:0]     ma, mb, big_m, small_m, shifted, m_big, m_small;
    logic [SUM_W-1:0]   sum;
    logic               a_big, sign_r, sign_eq;

    // exp=0 operands are zero: no hidden one
    assign ea      = op_a[30:23];
    assign eb      = op_b[30:23];
    assign ma      = (ea == '0) ? '0 : {1'b1, op_a[22:0]};
    assign mb      = (eb == '0) ? '0 : {1'b1, op_b[22:0]};
    assign a_big   = {ea, ma} >= {eb, mb};
    assign big_e   = a_big ? ea : eb;
    assign small_e = a_big ? eb : ea;
    assign big_m   = a_big ? ma : mb;
    assign small_m = a_big ? mb : ma;
    assign busy    = (state != IDLE);

    fp_align_shift u_shift (
        .mant    (small_m),
        .amt     (big_e - small_e),
        .shifted (shifted)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_a    <= '0;
            op_b    <= '0;
            m_big   <= '0;
            m_small <= '0;
            exp_r   <= '0;
            sign_r  <= 1'b0;
            sign_eq <= 1'b0;
            sum     <= '0;
            result  <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_a  <= a;
                    op_b  <= b;
                    state <= ALIGN;
                end
                ALIGN: begin
                    m_big   <= big_m;
                    m_small <= shifted;
                    exp_r   <= big_e;
                    sign_r  <= a_big ? op_a[31] : op_b[31];
                    sign_eq <= (op_a[31] == op_b[31]);
                    state   <= ADD;
                end
                ADD: begin
                    sum   <= sign_eq ? {1'b0, m_big} + {1'b0, m_small} : {1'b0, m_big} - {1'b0, m_small};
                    state <= NORM;
                end
                NORM: begin
                    if (sum == '0) begin
                        {result, ovf} <= {32'h0, 1'b0};
                        done          <= 1'b1;
                        state         <= DONE;
                    end else if (sum[MAN_W+1]) begin
                        {result, ovf} <= (exp_r >= EXP_W'(EXP_MAX - 1)) ? {sign_r, 8'hFF, 23'h0, 1'b1}
                                                                        : {sign_r, exp_r + 8'd1, sum[MAN_W:1], 1'b0};
                        done          <= 1'b1;
                        state         <= DONE;
                    end else if (sum[MAN_W]) begin
                        {result, ovf} <= (exp_r == EXP_W'(EXP_MAX)) ? {sign_r, 8'hFF, 23'h0, 1'b1}
                                                                    : {sign_r, exp_r, sum[MAN_W-1:0], 1'b0};
                        done          <= 1'b1;
                        state         <= DONE;
                    end else if (exp_r <= 8'd1) begin
                        {result, ovf} <= {32'h0, 1'b0};
                        done          <= 1'b1;
                        state         <= DONE;
                    end else begin
                        sum   <= sum << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: vector table plus scoreboard for fp_add_seq, with hand-built busy/reset sequences.
module tb_fp_add_seq;
    import fp_pkg::*;

    logic        clk, reset, start, busy, done, ovf;
    logic [31:0] a, b, result;
    int          cyc = 0;
    int          checks = 0;
    int          fails = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
        int          start_cyc;
    } exp_t;

    exp_t q[$];
    vec_t vecs[14];

    fp_add_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done actual_result=%h required=no_done", result);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk("ovf", {31'h0, ovf}, {31'h0, e.ovf});
                if (e.cyc != 0) chk("latency", 32'(cyc - e.start_cyc + 1), 32'(e.cyc));
            end
        end
    end

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] er,
                          input logic eo, input int ec);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        a     = va;
        b     = vb;
        start = 1'b1;
        q.push_back('{er, eo, ec, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL timeout a=%h b=%h actual=no_done required=done", va, vb);
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 4};
        vecs[1]  = '{32'h3FC00000, 32'hBF800000, 32'h3F000000, 1'b0, 5};
        vecs[2]  = '{32'h40400000, 32'hC0400000, 32'h00000000, 1'b0, 4};
        vecs[3]  = '{32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 4};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 4};
        vecs[5]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 4};
        vecs[6]  = '{32'h00000000, 32'hBF800000, 32'hBF800000, 1'b0, 4};
        vecs[7]  = '{32'h3F800000, 32'hBF7FFFFF, 32'h34000000, 1'b0, 27};
        vecs[8]  = '{32'h00800000, 32'h80C00000, 32'h00000000, 1'b0, 0};
        vecs[9]  = '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b1, 4};
        vecs[10] = '{32'h40000000, 32'h3F800000, 32'h40400000, 1'b0, 4};
        vecs[11] = '{32'hC0000000, 32'hC0000000, 32'hC0800000, 1'b0, 4};
        vecs[12] = '{32'h3F800000, 32'h347FFFFF, 32'h3F800001, 1'b0, 4};
        vecs[13] = '{32'h3F800000, 32'h33FFFFFF, 32'h3F800000, 1'b0, 4};

        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_ovf", {31'h0, ovf}, 32'h0);
        chk("rst_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].cyc);

        // new operands offered during NORM and held through DONE must not disturb the running add
        a     = 32'h3FC00000;
        b     = 32'hBF800000;
        start = 1'b1;
        q.push_back('{32'h3F000000, 1'b0, 5, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_in_norm", {31'h0, busy}, 32'h1);
        a     = 32'h7F7FFFFF;
        b     = 32'h7F7FFFFF;
        start = 1'b1;
        for (int n = 0; n < 20 && !done; n++) @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 10; n++) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'h0);
        q.delete();
        chk("result_held", result, 32'h3F000000);
        chk("idle_after", {31'h0, busy}, 32'h0);

        // reset during ALIGN aborts the add without a done
        a     = 32'h3F800000;
        b     = 32'h3F800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_align", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        chk("mid_rst_done", {31'h0, done}, 32'h0);
        chk("mid_rst_result", result, 32'h0);
        chk("mid_rst_ovf", {31'h0, ovf}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 8; n++) @(negedge clk);
        chk("no_done_after_rst", result, 32'h0);
        run_op(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
